// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the in-order
//   pipeline write-back stage (primary) and a multi-cycle secondary unit
//   (mul/div). Secondary results are queued in a small FIFO and drained
//   whenever the pipeline is not writing. A starvation counter forces a
//   one-cycle pipeline stall so that queued results cannot wait forever.
//   A per-register scoreboard reports which registers have a queued write.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   p_we/p_addr/p_data  pipeline write-back request
//   s_valid/s_addr/s_data, s_ready  secondary result handshake
//   p_stall             pipeline must hold write-back and earlier stages
//   we3/a3/wd3          register file write port (file latches on negedge)
//   q_addr1/q_addr2     decode source-register queries
//   q_busy1/q_busy2     queried register has a queued secondary write
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_we,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic        s_valid,
  input  logic [4:0]  s_addr,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        p_stall,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_busy1,
  output logic        q_busy2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          stall_flag;

  logic empty;
  logic full;
  logic p_req;
  logic enq;
  logic head_grant;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign p_req   = p_we & (p_addr != 5'd0);
  assign s_ready = ~full;
  // Writes to r0 complete the handshake but are dropped rather than queued.
  assign enq     = s_valid & s_ready & (s_addr != 5'd0);

  // Write-port grant. Outputs are forced idle while reset is asserted so a
  // pipeline request seen during reset cannot reach the register file.
  always_comb begin
    we3        = 1'b0;
    a3         = 5'd0;
    wd3        = 32'd0;
    p_stall    = 1'b0;
    head_grant = 1'b0;
    if (rst_n) begin
      if (stall_flag) begin
        p_stall    = 1'b1;
        head_grant = 1'b1;
        we3        = 1'b1;
        a3         = fifo_addr[head_ptr];
        wd3        = fifo_data[head_ptr];
      end else if (p_req) begin
        we3 = 1'b1;
        a3  = p_addr;
        wd3 = p_data;
      end else if (!empty) begin
        head_grant = 1'b1;
        we3        = 1'b1;
        a3         = fifo_addr[head_ptr];
        wd3        = fifo_data[head_ptr];
      end
    end
  end

  // Scoreboard: walk the occupied slots from head; only stored entries count,
  // so a handshake happening this cycle is not yet visible.
  always_comb begin
    logic [PW-1:0] idx;
    logic          hit1;
    logic          hit2;
    idx  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (fifo_addr[idx] == q_addr1) hit1 = 1'b1;
        if (fifo_addr[idx] == q_addr2) hit2 = 1'b1;
      end
    end
    q_busy1 = rst_n & hit1 & (q_addr1 != 5'd0);
    q_busy2 = rst_n & hit2 & (q_addr2 != 5'd0);
  end

  // FIFO storage; contents are only meaningful where count says so, so the
  // data array itself needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[tail_ptr] <= s_addr;
      fifo_data[tail_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a
  // power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq)        tail_ptr <= tail_ptr + PW'(1);
      if (head_grant) head_ptr <= head_ptr + PW'(1);
      case ({enq, head_grant})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation tracking: counts cycles the head waits while the pipeline
  // wins. Reaching the limit raises the stall flag for exactly one cycle;
  // that cycle grants the head, which clears both counter and flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_flag <= 1'b0;
    end else if (empty || head_grant) begin
      starve_cnt <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
      stall_flag <= (starve_cnt == SW'(STARVE_LIMIT - 1));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Self-checking bench for regfile_wb_arbiter (DEPTH=2, STARVE_LIMIT=4):
//   a directed vector table, hand-written multi-cycle sequences (back-pressure,
//   reset mid-drain, ordering with wrap) and randomized traffic compared
//   against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        s_valid;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        s_ready;
  logic        p_stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_busy1;
  logic        q_busy2;

  regfile_wb_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .p_we   (p_we),
    .p_addr (p_addr),
    .p_data (p_data),
    .s_valid(s_valid),
    .s_addr (s_addr),
    .s_data (s_data),
    .s_ready(s_ready),
    .p_stall(p_stall),
    .we3    (we3),
    .a3     (a3),
    .wd3    (wd3),
    .q_addr1(q_addr1),
    .q_addr2(q_addr2),
    .q_busy1(q_busy1),
    .q_busy2(q_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  // Reference model: queued results, wait cycles of the head, forced stall.
  entry_t model_q[$];
  int     model_wait;
  bit     model_stall;

  // Observed register-file writes, captured while capture_en is set.
  entry_t writes[$];
  bit     capture_en;

  typedef struct {
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        s_valid;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_ready;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
    input logic sv, input logic [4:0] sa, input logic [31:0] sd,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic er, input logic es, input logic ew,
    input logic [4:0] ea, input logic [31:0] ed,
    input logic b1, input logic b2);
    vec_t v;
    v.p_we = pwe; v.p_addr = pa; v.p_data = pd;
    v.s_valid = sv; v.s_addr = sa; v.s_data = sd;
    v.q1 = q1; v.q2 = q2;
    v.e_ready = er; v.e_stall = es; v.e_we = ew;
    v.e_a3 = ea; v.e_wd = ed; v.e_b1 = b1; v.e_b2 = b2;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(
    input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
    input logic sv, input logic [4:0] sa, input logic [31:0] sd,
    input logic [4:0] q1, input logic [4:0] q2);
    p_we    = pwe;
    p_addr  = pa;
    p_data  = pd;
    s_valid = sv;
    s_addr  = sa;
    s_data  = sd;
    q_addr1 = q1;
    q_addr2 = q2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with a live pipeline request to show the outputs stay idle,
  // then release between clock edges and clear the model.
  task automatic reset_all(input string tag);
    rst_n = 1'b0;
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    #3;
    check_output({tag, ".rst_s_ready"}, 32'(s_ready), 32'd1);
    check_output({tag, ".rst_p_stall"}, 32'(p_stall), 32'd0);
    check_output({tag, ".rst_we3"},     32'(we3),     32'd0);
    check_output({tag, ".rst_a3"},      32'(a3),      32'd0);
    check_output({tag, ".rst_wd3"},     wd3,          32'd0);
    check_output({tag, ".rst_busy1"},   32'(q_busy1), 32'd0);
    check_output({tag, ".rst_busy2"},   32'(q_busy2), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    model_q.delete();
    model_wait  = 0;
    model_stall = 0;
  endtask

  // One cycle against the reference model: predict from the queue, compare
  // at negedge, then advance the model with the inputs seen at posedge.
  task automatic model_cycle(input string tag);
    bit          full;
    bit          head_win;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_b1;
    logic        e_b2;
    int          size_before;
    full     = (model_q.size() == DEPTH);
    head_win = 0;
    e_we     = 1'b0;
    e_a3     = 5'd0;
    e_wd     = 32'd0;
    if (model_stall) begin
      head_win = 1;
    end else if (p_we && p_addr != 5'd0) begin
      e_we = 1'b1;
      e_a3 = p_addr;
      e_wd = p_data;
    end else if (model_q.size() > 0) begin
      head_win = 1;
    end
    if (head_win) begin
      e_we = 1'b1;
      e_a3 = model_q[0].addr;
      e_wd = model_q[0].data;
    end
    e_b1 = 1'b0;
    e_b2 = 1'b0;
    foreach (model_q[i]) begin
      if (q_addr1 != 5'd0 && model_q[i].addr == q_addr1) e_b1 = 1'b1;
      if (q_addr2 != 5'd0 && model_q[i].addr == q_addr2) e_b2 = 1'b1;
    end
    @(negedge clk);
    check_output({tag, ".s_ready"}, 32'(s_ready), 32'(!full));
    check_output({tag, ".p_stall"}, 32'(p_stall), 32'(model_stall));
    check_output({tag, ".we3"},     32'(we3),     32'(e_we));
    check_output({tag, ".a3"},      32'(a3),      32'(e_a3));
    check_output({tag, ".wd3"},     wd3,          e_wd);
    check_output({tag, ".busy1"},   32'(q_busy1), 32'(e_b1));
    check_output({tag, ".busy2"},   32'(q_busy2), 32'(e_b2));
    if (capture_en && we3) writes.push_back('{a3, wd3});
    @(posedge clk);
    size_before = model_q.size();
    if (head_win) void'(model_q.pop_front());
    if (s_valid && !full && s_addr != 5'd0) model_q.push_back('{s_addr, s_data});
    if (size_before == 0 || head_win) begin
      model_wait  = 0;
      model_stall = 0;
    end else begin
      if (model_wait < STARVE_LIMIT) model_wait++;
      model_stall = (model_wait == STARVE_LIMIT);
    end
    #1;
  endtask

  initial begin
    capture_en = 0;
    reset_all("init");

    // Directed table: idle secondary write, register zero, pipeline priority
    // with a single forced stall after four starved cycles.
    vecs[0]  = mk(1'b0, 5'd0, 32'd0,      1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0,
                  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,        5'd5, 5'd6,
                  1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,        5'd5, 5'd0,
                  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 5'd0, 32'd0,      1'b1, 5'd9, 32'h99,       5'd9, 5'd0,
                  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 5'd0, 32'h1234,   1'b1, 5'd0, 32'h55,       5'd9, 5'd0,
                  1'b1, 1'b0, 1'b1, 5'd9, 32'h99,       1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,        5'd0, 5'd9,
                  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 5'd3, 32'h33,     1'b1, 5'd7, 32'h77,       5'd7, 5'd0,
                  1'b1, 1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 1'b0);
    for (int i = 7; i <= 10; i++)
      vecs[i] = mk(1'b1, 5'd3, 32'h33,    1'b0, 5'd0, 32'd0,        5'd7, 5'd0,
                   1'b1, 1'b0, 1'b1, 5'd3, 32'h33,      1'b1, 1'b0);
    vecs[11] = mk(1'b1, 5'd3, 32'h33,     1'b0, 5'd0, 32'd0,        5'd7, 5'd0,
                  1'b1, 1'b1, 1'b1, 5'd7, 32'h77,       1'b1, 1'b0);
    vecs[12] = mk(1'b1, 5'd3, 32'h33,     1'b0, 5'd0, 32'd0,        5'd7, 5'd0,
                  1'b1, 1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].p_we, vecs[i].p_addr, vecs[i].p_data,
                     vecs[i].s_valid, vecs[i].s_addr, vecs[i].s_data,
                     vecs[i].q1, vecs[i].q2);
      @(negedge clk);
      check_output($sformatf("vec%0d.s_ready", i), 32'(s_ready), 32'(vecs[i].e_ready));
      check_output($sformatf("vec%0d.p_stall", i), 32'(p_stall), 32'(vecs[i].e_stall));
      check_output($sformatf("vec%0d.we3", i),     32'(we3),     32'(vecs[i].e_we));
      check_output($sformatf("vec%0d.a3", i),      32'(a3),      32'(vecs[i].e_a3));
      check_output($sformatf("vec%0d.wd3", i),     wd3,          vecs[i].e_wd);
      check_output($sformatf("vec%0d.busy1", i),   32'(q_busy1), 32'(vecs[i].e_b1));
      check_output($sformatf("vec%0d.busy2", i),   32'(q_busy2), 32'(vecs[i].e_b2));
      tick();
    end

    // Back-pressure: pipeline writes r3 every cycle, two results fill the
    // FIFO, a third is held until the forced drain frees a slot.
    reset_all("full");
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0, 5'd10, 5'd11);
    @(negedge clk);
    check_output("full.a_ready", 32'(s_ready), 32'd1);
    check_output("full.a_a3",    32'(a3),      32'd3);
    tick();
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hB0, 5'd10, 5'd11);
    @(negedge clk);
    check_output("full.b_ready", 32'(s_ready), 32'd1);
    check_output("full.b_busy1", 32'(q_busy1), 32'd1);
    check_output("full.b_busy2", 32'(q_busy2), 32'd0);
    tick();
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC0, 5'd10, 5'd11);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output($sformatf("full.hold%0d_ready", c), 32'(s_ready), 32'd0);
      check_output($sformatf("full.hold%0d_stall", c), 32'(p_stall), 32'd0);
      check_output($sformatf("full.hold%0d_a3", c),    32'(a3),      32'd3);
      check_output($sformatf("full.hold%0d_busy2", c), 32'(q_busy2), 32'd1);
      tick();
    end
    @(negedge clk);
    check_output("full.drain_stall", 32'(p_stall), 32'd1);
    check_output("full.drain_a3",    32'(a3),      32'd10);
    check_output("full.drain_wd3",   wd3,          32'hA0);
    check_output("full.drain_ready", 32'(s_ready), 32'd0);
    tick();
    q_addr1 = 5'd12;
    @(negedge clk);
    check_output("full.after_ready", 32'(s_ready), 32'd1);
    check_output("full.after_stall", 32'(p_stall), 32'd0);
    check_output("full.after_a3",    32'(a3),      32'd3);
    check_output("full.after_busy1", 32'(q_busy1), 32'd0);
    tick();

    // Reset mid-drain: r11 and r12 are queued and the head is being granted.
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd11);
    @(negedge clk);
    check_output("mid.pre_we3",   32'(we3),     32'd1);
    check_output("mid.pre_a3",    32'(a3),      32'd11);
    check_output("mid.pre_busy1", 32'(q_busy1), 32'd1);
    check_output("mid.pre_ready", 32'(s_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid.rst_we3",   32'(we3),     32'd0);
    check_output("mid.rst_ready", 32'(s_ready), 32'd1);
    check_output("mid.rst_busy1", 32'(q_busy1), 32'd0);
    check_output("mid.rst_busy2", 32'(q_busy2), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output($sformatf("mid.post%0d_we3", c),   32'(we3),     32'd0);
      check_output($sformatf("mid.post%0d_busy1", c), 32'(q_busy1), 32'd0);
      tick();
    end

    // Ordering and pointer wrap: r1..r6 interleaved with idle cycles.
    reset_all("order");
    writes.delete();
    capture_en = 1;
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'hC0DE0000 | 32'(i),
                     5'(i), 5'(i + 1));
      model_cycle($sformatf("order.hs%0d", i));
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i + 1));
      model_cycle($sformatf("order.idle%0d", i));
    end
    capture_en = 0;
    check_output("order.count", 32'(writes.size()), 32'd6);
    for (int i = 0; i < 6 && i < writes.size(); i++) begin
      check_output($sformatf("order.w%0d_addr", i), 32'(writes[i].addr), 32'(i + 1));
      check_output($sformatf("order.w%0d_data", i), writes[i].data,
                   32'hC0DE0000 | 32'(i + 1));
    end

    // Randomized traffic against the reference model.
    reset_all("rand");
    for (int n = 0; n < 600; n++) begin
      apply_stimulus(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                     5'($urandom_range(0, 7)), $urandom(),
                     ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                     5'($urandom_range(0, 7)), $urandom(),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      model_cycle($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
